// File: rtl/ppm_pkg.sv
// Shared constants and state encoding for the 4-PPM frame transmitter.
package ppm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StPayload,
    StGuard
  } ppm_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE         = 8'hAA;
  localparam logic [7:0]  SFD_A                 = 8'hFC;
  localparam logic [7:0]  SFD_B                 = 8'hF3;
  localparam int unsigned SLOTS_PER_SYM         = 4;
  localparam int unsigned DEFAULT_PAYLOAD_BYTES = 148;

endpackage

// File: rtl/ppm_symbol_mapper.sv
// 4-PPM symbol mapper: pulse is high only in the slot whose index equals the symbol.
module ppm_symbol_mapper (
  input  logic [1:0] symbol_i,
  input  logic [1:0] slot_i,
  output logic       pulse_o
);

  // One pulse per symbol, positioned by the symbol value
  always_comb begin
    pulse_o = (symbol_i == slot_i);
  end

endmodule

// File: rtl/ppm_frame_tx.sv
// 4-PPM frame transmitter: preamble, two-byte SFD, payload from a one-byte
// holding register, then a forced-low guard interval. One slot per clock.
module ppm_frame_tx
  import ppm_pkg::*;
#(
  parameter int unsigned PRE_BYTES     = 4,
  parameter int unsigned PAYLOAD_BYTES = DEFAULT_PAYLOAD_BYTES,
  parameter int unsigned GUARD_SLOTS   = 8
) (
  input  logic       clk4m,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       ppm_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned ByteCntW  = $clog2(PRE_BYTES + PAYLOAD_BYTES + 2);
  localparam int unsigned GuardCntW = (GUARD_SLOTS > 1) ? $clog2(GUARD_SLOTS) : 1;

  localparam logic [ByteCntW-1:0]  PreLast   = ByteCntW'(PRE_BYTES - 1);
  localparam logic [ByteCntW-1:0]  PayLast   = ByteCntW'(PAYLOAD_BYTES - 1);
  localparam logic [GuardCntW-1:0] GuardLast = GuardCntW'(GUARD_SLOTS - 1);

  ppm_state_e           state_q, state_d;
  logic [1:0]           slot_q, slot_d;
  logic [1:0]           sym_q, sym_d;
  logic [ByteCntW-1:0]  byte_q, byte_d;
  logic [GuardCntW-1:0] guard_q, guard_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 underrun_q, underrun_d;

  logic       sym_end, byte_end, in_data, in_tx, last_payload;
  logic       xfer, load_boundary;
  logic [7:0] next_payload;
  logic       map_pulse;

  ppm_symbol_mapper u_mapper (
    .symbol_i (shift_q[7:6]),
    .slot_i   (slot_q),
    .pulse_o  (map_pulse)
  );

  // Decode field position, handshake and the payload byte to load at a boundary
  always_comb begin
    sym_end       = (slot_q == 2'd3);
    byte_end      = sym_end && (sym_q == 2'd3);
    in_data       = (state_q == StSfd) || (state_q == StPayload);
    in_tx         = (state_q == StPreamble) || in_data;
    // Once the final payload byte is in the shifter nothing more is accepted
    last_payload  = (state_q == StPayload) && (byte_q == PayLast);
    data_ready    = in_data && !hold_full_q && !last_payload;
    xfer          = data_valid && data_ready;
    load_boundary = byte_end &&
                    (((state_q == StSfd) && (byte_q == ByteCntW'(1))) ||
                     ((state_q == StPayload) && !last_payload));
    // Holding register first, else forward a same-cycle transfer, else fill with zero
    if (hold_full_q) begin
      next_payload = hold_q;
    end else if (xfer) begin
      next_payload = data_in;
    end else begin
      next_payload = 8'h00;
    end
    ppm_out    = in_tx && map_pulse;
    busy       = (state_q != StIdle);
    frame_done = (state_q == StGuard) && (guard_q == GuardLast);
    underrun   = underrun_q;
  end

  // Next-state logic for the frame sequencer, counters and holding register
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    sym_d       = sym_q;
    byte_d      = byte_q;
    guard_d     = guard_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;

    // A transfer coinciding with a load is forwarded, so it never lands here
    if (xfer && !load_boundary) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
    if (load_boundary) begin
      hold_full_d = 1'b0;
      if (!hold_full_q && !xfer) begin
        underrun_d = 1'b1;
      end
    end

    if (in_tx) begin
      slot_d = slot_q + 2'd1;
      if (sym_end) begin
        sym_d   = sym_q + 2'd1;
        shift_d = {shift_q[5:0], 2'b00};
      end
      if (byte_end) begin
        byte_d = byte_q + ByteCntW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StPreamble;
          slot_d     = 2'd0;
          sym_d      = 2'd0;
          byte_d     = '0;
          shift_d    = PREAMBLE_BYTE;
          underrun_d = 1'b0;
        end
      end
      StPreamble: begin
        if (byte_end) begin
          if (byte_q == PreLast) begin
            state_d     = StSfd;
            byte_d      = '0;
            shift_d     = SFD_A;
            hold_full_d = 1'b0;
          end else begin
            shift_d = PREAMBLE_BYTE;
          end
        end
      end
      StSfd: begin
        if (byte_end) begin
          if (byte_q == '0) begin
            shift_d = SFD_B;
          end else begin
            state_d = StPayload;
            byte_d  = '0;
            shift_d = next_payload;
          end
        end
      end
      StPayload: begin
        if (byte_end) begin
          if (last_payload) begin
            state_d = StGuard;
            byte_d  = '0;
            guard_d = '0;
            shift_d = 8'h00;
          end else begin
            shift_d = next_payload;
          end
        end
      end
      StGuard: begin
        guard_d = guard_q + GuardCntW'(1);
        if (guard_q == GuardLast) begin
          state_d = StIdle;
          guard_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk4m) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      slot_q      <= 2'd0;
      sym_q       <= 2'd0;
      byte_q      <= '0;
      guard_q     <= '0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sym_q       <= sym_d;
      byte_q      <= byte_d;
      guard_q     <= guard_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ppm_frame_tx.sv
// Directed bench for ppm_frame_tx: decodes the slot stream back into bytes and
// compares against hand-built frame contents and timing.
module tb_ppm_frame_tx;

  localparam int PRE       = 4;
  localparam int PAY       = 148;
  localparam int GUARD     = 8;
  localparam int NB        = PRE + 2 + PAY;
  localparam int FRAME_LEN = NB * 16 + GUARD;

  logic       clk4m;
  logic       reset_n;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       ppm_out;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay   [0:PAY-1];
  logic [7:0] exp_b [0:NB-1];
  bit         fb    [0:FRAME_LEN-1];

  // Driver state
  int k        = 0;
  int sup_cnt  = 0;
  bit xfer_prev = 0;
  bit under_mode = 0;

  // Capture state filled by run_frame
  logic cap_busy0, cap_under0, cap_busy_end, cap_under_end;
  bit   cap_idle_bad;

  ppm_frame_tx #(
    .PRE_BYTES     (PRE),
    .PAYLOAD_BYTES (PAY),
    .GUARD_SLOTS   (GUARD)
  ) dut (
    .clk4m      (clk4m),
    .reset_n    (reset_n),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ppm_out    (ppm_out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial clk4m = 1'b0;
  always #5 clk4m = ~clk4m;

  // Data source: offers pay[k] every cycle; optionally withholds byte 5 for 40 cycles
  initial begin
    data_in    = 8'h00;
    data_valid = 1'b0;
    forever begin
      @(negedge clk4m);
      if (xfer_prev) k++;
      if (!busy) begin
        k       = 0;
        sup_cnt = 0;
      end
      if (under_mode && k == 5 && sup_cnt < 40) begin
        sup_cnt++;
        data_valid = 1'b0;
      end else begin
        data_valid = 1'b1;
      end
      data_in   = (k < PAY) ? pay[k] : 8'h55;
      xfer_prev = data_ready && data_valid;
    end
  end

  function automatic logic [8:0] decode_byte(input int i);
    logic [7:0] v;
    logic       bad;
    int         cnt;
    v   = 8'h00;
    bad = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cnt = 0;
      for (int p = 0; p < 4; p++) begin
        if (fb[i*16 + s*4 + p]) begin
          cnt++;
          v[7-2*s -: 2] = p[1:0];
        end
      end
      if (cnt != 1) bad = 1'b1;
    end
    return {bad, v};
  endfunction

  task automatic build_exp(input bit with_under);
    for (int i = 0; i < PRE; i++) exp_b[i] = 8'hAA;
    exp_b[PRE]   = 8'hFC;
    exp_b[PRE+1] = 8'hF3;
    for (int j = 0; j < PAY; j++) begin
      if (!with_under || j < 5) exp_b[PRE+2+j] = pay[j];
      else if (j == 5)          exp_b[PRE+2+j] = 8'h00;
      else                      exp_b[PRE+2+j] = pay[j-1];
    end
  endtask

  // Pulse start, then record one slot per cycle from the first preamble slot (t=0)
  task automatic run_frame(input int glitch_t, input int rst_t, output int done_t,
                           output int done_cnt, output int first_t, output bit aborted);
    done_t       = -1;
    done_cnt     = 0;
    first_t      = -1;
    aborted      = 1'b0;
    cap_idle_bad = 1'b0;
    cap_busy_end = 1'bx;
    cap_under_end = 1'bx;
    for (int t = 0; t < FRAME_LEN; t++) fb[t] = 1'b0;
    @(negedge clk4m);
    start = 1'b1;
    @(negedge clk4m);
    start      = 1'b0;
    cap_busy0  = busy;
    cap_under0 = underrun;
    for (int t = 0; t < FRAME_LEN + 40; t++) begin
      if (t > 0) @(negedge clk4m);
      if (t < FRAME_LEN) fb[t] = ppm_out;
      if (ppm_out && first_t < 0) first_t = t;
      if (frame_done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (t == FRAME_LEN) begin
        cap_busy_end  = busy;
        cap_under_end = underrun;
      end
      if (t >= FRAME_LEN && (ppm_out || busy)) cap_idle_bad = 1'b1;
      start = (t == glitch_t);
      if (t == rst_t) begin
        reset_n = 1'b0;
        @(negedge clk4m);
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk4m);
    checks++; if (ppm_out !== 1'b0)    begin errors++; $display("FAIL reset_ppm got %b exp 0", ppm_out); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", data_ready); end
    checks++; if (underrun !== 1'b0)   begin errors++; $display("FAIL reset_under got %b exp 0", underrun); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk4m);
    checks++; if (busy !== 1'b0 || ppm_out !== 1'b0)
      begin errors++; $display("FAIL idle_hold got busy=%b ppm=%b exp 0 0", busy, ppm_out); end
  endtask

  task automatic test_basic_frame();
    int done_t, done_cnt, first_t;
    bit aborted;
    logic [8:0] d;
    int exp_slot [0:7];
    exp_slot = '{0, 1, 2, 3, 3, 2, 1, 0};
    build_exp(1'b0);
    run_frame(-1, -1, done_t, done_cnt, first_t, aborted);
    checks++; if (cap_busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy0 got %b exp 1", cap_busy0); end
    checks++; if (first_t != 2) begin errors++; $display("FAIL basic_first_pulse got %0d exp 2", first_t); end
    checks++; if (done_t != FRAME_LEN - 1)
      begin errors++; $display("FAIL basic_done_t got %0d exp %0d", done_t, FRAME_LEN - 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (cap_under_end !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b exp 0", cap_under_end); end
    checks++; if (cap_busy_end !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", cap_busy_end); end
    checks++; if (cap_idle_bad) begin errors++; $display("FAIL basic_idle got activity exp none"); end
    for (int i = 0; i < NB; i++) begin
      d = decode_byte(i);
      checks++;
      if (d[8] || d[7:0] !== exp_b[i])
        begin errors++; $display("FAIL basic_byte%0d got %h bad=%b exp %h", i, d[7:0], d[8], exp_b[i]); end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (fb[(PRE+2)*16 + s*4 + exp_slot[s]] !== 1'b1)
        begin errors++; $display("FAIL basic_slot_sym%0d got 0 exp 1 in slot %0d", s, exp_slot[s]); end
    end
    begin
      bit gbad = 1'b0;
      for (int t = NB*16; t < FRAME_LEN; t++) if (fb[t]) gbad = 1'b1;
      checks++; if (gbad) begin errors++; $display("FAIL basic_guard got pulse exp none"); end
    end
  endtask

  task automatic test_underrun();
    int done_t, done_cnt, first_t;
    bit aborted;
    logic [8:0] d;
    under_mode = 1'b1;
    build_exp(1'b1);
    run_frame(-1, -1, done_t, done_cnt, first_t, aborted);
    under_mode = 1'b0;
    checks++; if (cap_under0 !== 1'b0) begin errors++; $display("FAIL under_start got %b exp 0", cap_under0); end
    checks++; if (done_t != FRAME_LEN - 1)
      begin errors++; $display("FAIL under_done_t got %0d exp %0d", done_t, FRAME_LEN - 1); end
    checks++; if (cap_under_end !== 1'b1) begin errors++; $display("FAIL under_sticky got %b exp 1", cap_under_end); end
    for (int i = 0; i < NB; i++) begin
      d = decode_byte(i);
      checks++;
      if (d[8] || d[7:0] !== exp_b[i])
        begin errors++; $display("FAIL under_byte%0d got %h bad=%b exp %h", i, d[7:0], d[8], exp_b[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int done_t, done_cnt, first_t;
    bit aborted;
    logic [8:0] d;
    build_exp(1'b0);
    run_frame((PRE + 2 + 10) * 16 + 3, -1, done_t, done_cnt, first_t, aborted);
    checks++; if (cap_under0 !== 1'b0) begin errors++; $display("FAIL ign_under_clear got %b exp 0", cap_under0); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_t != FRAME_LEN - 1)
      begin errors++; $display("FAIL ign_done_t got %0d exp %0d", done_t, FRAME_LEN - 1); end
    checks++; if (cap_idle_bad || cap_busy_end !== 1'b0)
      begin errors++; $display("FAIL ign_idle got busy=%b activity=%b exp 0 0", cap_busy_end, cap_idle_bad); end
    for (int i = 0; i < NB; i++) begin
      d = decode_byte(i);
      checks++;
      if (d[8] || d[7:0] !== exp_b[i])
        begin errors++; $display("FAIL ign_byte%0d got %h bad=%b exp %h", i, d[7:0], d[8], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int done_t, done_cnt, first_t;
    bit aborted;
    logic [8:0] d;
    build_exp(1'b0);
    run_frame(-1, PRE * 16 + 5, done_t, done_cnt, first_t, aborted);
    checks++; if (!aborted) begin errors++; $display("FAIL rst_abort got 0 exp 1"); end
    checks++; if (ppm_out !== 1'b0)    begin errors++; $display("FAIL rst_ppm got %b exp 0", ppm_out); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", data_ready); end
    checks++; if (done_cnt != 0 || frame_done !== 1'b0)
      begin errors++; $display("FAIL rst_done got cnt=%0d now=%b exp 0 0", done_cnt, frame_done); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk4m);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_resume got %b exp 0", busy); end
    run_frame(-1, -1, done_t, done_cnt, first_t, aborted);
    checks++; if (done_t != FRAME_LEN - 1 || done_cnt != 1)
      begin errors++; $display("FAIL rst_refr_done got t=%0d cnt=%0d exp %0d 1", done_t, done_cnt, FRAME_LEN - 1); end
    checks++; if (cap_under_end !== 1'b0) begin errors++; $display("FAIL rst_refr_under got %b exp 0", cap_under_end); end
    for (int i = 0; i < NB; i++) begin
      d = decode_byte(i);
      checks++;
      if (d[8] || d[7:0] !== exp_b[i])
        begin errors++; $display("FAIL rst_byte%0d got %h bad=%b exp %h", i, d[7:0], d[8], exp_b[i]); end
    end
  endtask

  initial begin
    pay[0] = 8'h1B;
    pay[1] = 8'hE4;
    for (int j = 2; j < PAY; j++) pay[j] = 8'((j * 37 + 11) % 256);
    reset_n = 1'b0;
    start   = 1'b0;
    test_reset();
    test_basic_frame();
    test_underrun();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
